fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the PC/fetch stage: launches a selected program, passes decoded branch
//  kind to the fetch branch controls, freezes the PC while data memory is busy, and
//  stops fetch on a halt instruction. It sits between the decoder/memory and the fetch
//  unit and drives that unit's BranchEZ/BranchNZ/BranchAlways, Target and done inputs.
// PARAMETERS
//  W      8   jump target pointer width (matches fetch Target)
//  NPROG  3   number of launchable programs, bases in PROG_BASE (package)
//  CW     16  cycle counter width
// PORTS
//  Clk          in   1      clock, all state on posedge
//  Reset        in   1      asynchronous, active-low reset (0 = reset)
//  Start        in   1      level; request program launch
//  ProgSel      in   2      program index for launch, sampled in IDLE/HALT
//  InstBr       in   2      decoded branch kind: 00 none, 01 EZ, 10 NZ, 11 always
//  InstTarget   in   W      decoded branch target pointer
//  InstHalt     in   1      current instruction is halt
//  MemBusy      in   1      data memory needs another cycle; hold PC
//  BranchEZ     out  1      to fetch; one-hot with NZ/Always, or all 0
//  BranchNZ     out  1      to fetch
//  BranchAlways out  1      to fetch
//  Target       out  W      to fetch Target
//  done         out  1      to fetch: 1 = hold PC
//  Busy         out  1      program in flight (LAUNCH/RUN/STALL)
//  Finished     out  1      last program reached halt; cleared on next launch
//  CycleCount   out  CW     cycles of the last/current program
// BEHAVIOUR
//  States: IDLE, LAUNCH, RUN, STALL, HALT. Reset (Reset=0) -> IDLE, any cycle, incl.
//   mid-program; Finished=0, CycleCount=0; comb outputs then follow IDLE row below.
//  IDLE:   done=1, branches 0. Start && ProgSel<NPROG -> LAUNCH. ProgSel>=NPROG: no-op.
//  LAUNCH: one cycle. BranchAlways=1, Target=PROG_BASE[sel latched], done=0,
//          CycleCount<=0, Finished<=0 -> RUN.
//  RUN:    done=0. Priority InstHalt > MemBusy > branch:
//          InstHalt -> HALT, branches 0, done=1 (PC not advanced past halt);
//          MemBusy -> STALL, branches 0, done=1 this cycle;
//          else BranchEZ/NZ/Always = decode of InstBr, Target=InstTarget; stay RUN.
//  STALL:  done=1, branches 0; MemBusy=0 -> RUN (PC advances next RUN cycle).
//  HALT:   done=1, Finished=1, branches 0. Start && valid ProgSel -> LAUNCH.
//  Start in LAUNCH/RUN/STALL ignored (no mid-program restart).
//  Branch/done/Target outputs combinational from state + inputs (fetch samples
//   them next edge); zero-flag qualification stays in fetch.
//  Target=0 whenever no branch output asserted.
//  CycleCount: +1 each RUN/STALL cycle, saturates at all-ones, holds in HALT/IDLE.
//  Busy = state in {LAUNCH,RUN,STALL}. ProgSel latched on LAUNCH entry.
// STRUCTURE
//  fetch_pkg: state enum fc_state_t, branch kind enum br_kind_t (BR_NONE/EZ/NZ/ALWAYS),
//   localparam NPROG, PROG_BASE[NPROG] = {8'h00, 8'h40, 8'h80}.
//  One sub-module natural: sat_counter #(CW) (clear, enable, saturating count).
//  Remainder: single FSM always_ff + always_comb output decode.
// TESTING
//  1 Reset=0 mid-RUN, CycleCount=5 -> same cycle IDLE, done=1, Busy=0, count 0.
//  2 IDLE, Start=1 ProgSel=1 -> next cycle BranchAlways=1 Target=8'h40; then RUN.
//  3 RUN, InstBr=01 InstTarget=8'h12 -> BranchEZ=1 only, Target=8'h12; InstBr=11 -> Always.
//  4 RUN, MemBusy=1 for 3 cycles -> done=1 3 cycles, branches 0, CycleCount +3.
//  5 RUN, InstHalt=1 with MemBusy=1 InstBr=11 -> HALT, branches 0, Finished=1, count frozen.
//  6 IDLE Start=1 ProgSel=3 -> stays IDLE; HALT Start ProgSel=2 -> Target=8'h80, Finished=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller: FSM states,
// branch kinds and the base addresses of the launchable programs.
package fetch_pkg;

  localparam int NPROG = 3;
  localparam logic [1:0] NPROG_SEL = 2'(NPROG);
  localparam logic [7:0] PROG_BASE [NPROG] = '{8'h00, 8'h40, 8'h80};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_STALL,
    ST_HALT
  } fc_state_t;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_EZ     = 2'b01,
    BR_NZ     = 2'b10,
    BR_ALWAYS = 2'b11
  } br_kind_t;

  // Out-of-range selectors map to 0; the controller only ever passes a latched valid one.
  function automatic logic [7:0] progBase(input logic [1:0] sel);
    progBase = 8'h00;
    for (int i = 0; i < NPROG; i++) begin
      if (sel == 2'(i)) progBase = PROG_BASE[i];
    end
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: launches a program, forwards decoded branches to the
// fetch unit, holds the PC while data memory is busy and stops on halt.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic [1:0]    InstBr,
  input  logic [W-1:0]  InstTarget,
  input  logic          InstHalt,
  input  logic          MemBusy,
  output logic          BranchEZ,
  output logic          BranchNZ,
  output logic          BranchAlways,
  output logic [W-1:0]  Target,
  output logic          done,
  output logic          Busy,
  output logic          Finished,
  output logic [CW-1:0] CycleCount
);

  fc_state_t  r_state;
  fc_state_t  w_next;
  logic [1:0] r_sel;
  logic       r_finished;
  logic       w_launch;
  logic       w_ez;
  logic       w_nz;
  logic       w_always;
  logic       w_done;
  logic [W-1:0] w_target;

  assign w_launch = ((r_state == ST_IDLE) || (r_state == ST_HALT)) &&
                    Start && (ProgSel < NPROG_SEL);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_finished <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_launch) r_sel <= ProgSel;
      if (r_state == ST_LAUNCH) begin
        r_finished <= 1'b0;
      end else if ((r_state == ST_RUN) && InstHalt) begin
        r_finished <= 1'b1;
      end
    end
  end

  // Halt outranks a memory stall, which outranks any decoded branch.
  always_comb begin
    w_next   = r_state;
    w_ez     = 1'b0;
    w_nz     = 1'b0;
    w_always = 1'b0;
    w_target = '0;
    w_done   = 1'b1;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_launch) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_always = 1'b1;
        w_target = W'(progBase(r_sel));
        w_done   = 1'b0;
        w_next   = ST_RUN;
      end
      ST_RUN: begin
        if (InstHalt) begin
          w_next = ST_HALT;
        end else if (MemBusy) begin
          w_next = ST_STALL;
        end else begin
          w_done = 1'b0;
          case (br_kind_t'(InstBr))
            BR_EZ:     w_ez     = 1'b1;
            BR_NZ:     w_nz     = 1'b1;
            BR_ALWAYS: w_always = 1'b1;
            default:   ;
          endcase
          if (InstBr != BR_NONE) w_target = InstTarget;
        end
      end
      ST_STALL: begin
        if (!MemBusy) w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  sat_counter #(.CW(CW)) u_cycles (
    .clk      (Clk),
    .rst_n    (Reset),
    .i_clear  (r_state == ST_LAUNCH),
    .i_enable ((r_state == ST_RUN) || (r_state == ST_STALL)),
    .o_count  (CycleCount)
  );

  assign BranchEZ     = w_ez;
  assign BranchNZ     = w_nz;
  assign BranchAlways = w_always;
  assign Target       = w_target;
  assign done         = w_done;
  assign Busy         = (r_state == ST_LAUNCH) || (r_state == ST_RUN) || (r_state == ST_STALL);
  assign Finished     = r_finished;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed program scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_fetch_ctrl;

  localparam int W  = 8;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    ProgSel;
  logic [1:0]    InstBr;
  logic [W-1:0]  InstTarget;
  logic          InstHalt;
  logic          MemBusy;
  logic          BranchEZ;
  logic          BranchNZ;
  logic          BranchAlways;
  logic [W-1:0]  Target;
  logic          done;
  logic          Busy;
  logic          Finished;
  logic [CW-1:0] CycleCount;

  int errors = 0;
  int checks = 0;

  typedef enum int {M_IDLE, M_LAUNCH, M_RUN, M_STALL, M_HALT} mphase_t;
  mphase_t mPhase;
  int      mSel;
  int      mCnt;
  int      mFin;
  int      bases [3] = '{0, 64, 128};

  always #5 Clk = ~Clk;

  fetch_ctrl #(.W(W), .CW(CW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .ProgSel      (ProgSel),
    .InstBr       (InstBr),
    .InstTarget   (InstTarget),
    .InstHalt     (InstHalt),
    .MemBusy      (MemBusy),
    .BranchEZ     (BranchEZ),
    .BranchNZ     (BranchNZ),
    .BranchAlways (BranchAlways),
    .Target       (Target),
    .done         (done),
    .Busy         (Busy),
    .Finished     (Finished),
    .CycleCount   (CycleCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected combinational outputs follow from the model phase and the live inputs.
  task automatic checkAll(input string tag);
    int eEz, eNz, eAl, eTgt, eDone, eBusy;
    eEz = 0; eNz = 0; eAl = 0; eTgt = 0; eDone = 1;
    case (mPhase)
      M_LAUNCH: begin
        eAl = 1; eTgt = bases[mSel]; eDone = 0;
      end
      M_RUN: begin
        if (!InstHalt && !MemBusy) begin
          eDone = 0;
          eEz = (InstBr == 2'd1) ? 1 : 0;
          eNz = (InstBr == 2'd2) ? 1 : 0;
          eAl = (InstBr == 2'd3) ? 1 : 0;
          eTgt = (InstBr != 2'd0) ? int'(InstTarget) : 0;
        end
      end
      default: ;
    endcase
    eBusy = (mPhase == M_LAUNCH || mPhase == M_RUN || mPhase == M_STALL) ? 1 : 0;
    checkOutput({tag, ".ez"},   BranchEZ,     eEz);
    checkOutput({tag, ".nz"},   BranchNZ,     eNz);
    checkOutput({tag, ".al"},   BranchAlways, eAl);
    checkOutput({tag, ".tgt"},  Target,       eTgt);
    checkOutput({tag, ".done"}, done,         eDone);
    checkOutput({tag, ".busy"}, Busy,         eBusy);
    checkOutput({tag, ".fin"},  Finished,     mFin);
    checkOutput({tag, ".cnt"},  CycleCount,   mCnt);
  endtask

  task automatic modelStep();
    case (mPhase)
      M_IDLE, M_HALT: begin
        if (Start && (int'(ProgSel) < 3)) begin
          mPhase = M_LAUNCH;
          mSel = int'(ProgSel);
        end
      end
      M_LAUNCH: begin
        mCnt = 0; mFin = 0; mPhase = M_RUN;
      end
      M_RUN: begin
        if (mCnt < CNT_MAX) mCnt++;
        if (InstHalt) begin
          mPhase = M_HALT; mFin = 1;
        end else if (MemBusy) begin
          mPhase = M_STALL;
        end
      end
      M_STALL: begin
        if (mCnt < CNT_MAX) mCnt++;
        if (!MemBusy) mPhase = M_RUN;
      end
      default: ;
    endcase
  endtask

  // Advance one clock, then drive the new inputs on the falling edge and check.
  task automatic applyStimulus(input bit st, input int sel, input int br, input int tgt,
                               input bit halt, input bit busy, input bit doCheck,
                               input string tag);
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    Start      = st;
    ProgSel    = sel[1:0];
    InstBr     = br[1:0];
    InstTarget = tgt[W-1:0];
    InstHalt   = halt;
    MemBusy    = busy;
    #1;
    if (doCheck) checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    Reset = 1'b0;
    #1;
    mPhase = M_IDLE; mCnt = 0; mFin = 0;
    checkAll(tag);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; ProgSel = '0; InstBr = '0; InstTarget = '0;
    InstHalt = 1'b0; MemBusy = 1'b0;
    mPhase = M_IDLE; mSel = 0; mCnt = 0; mFin = 0;
    @(negedge Clk);
    #1;
    checkAll("por");
    Reset = 1'b1;

    // Launch program 1, then decoded branches
    applyStimulus(1, 1, 0, 0, 0, 0, 1, "idle");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "launch");
    checkOutput("t2.al", BranchAlways, 1);
    checkOutput("t2.tgt", Target, 8'h40);
    checkOutput("t2.done", done, 0);
    applyStimulus(1, 2, 1, 8'h12, 0, 0, 1, "runEz");
    checkOutput("t3.ez", BranchEZ, 1);
    checkOutput("t3.al", BranchAlways, 0);
    checkOutput("t3.tgt", Target, 8'h12);
    applyStimulus(0, 0, 3, 8'h34, 0, 0, 1, "runAl");
    checkOutput("t3.al2", BranchAlways, 1);
    checkOutput("t3.tgt2", Target, 8'h34);

    // Three memory-busy cycles freeze the PC
    applyStimulus(0, 0, 3, 8'h56, 0, 1, 1, "stall0");
    checkOutput("t4.done", done, 1);
    checkOutput("t4.al", BranchAlways, 0);
    applyStimulus(0, 0, 2, 8'h56, 0, 1, 1, "stall1");
    applyStimulus(0, 0, 1, 8'h56, 0, 1, 1, "stall2");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "stall3");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "resume");
    checkOutput("t4.cnt", CycleCount, 6);
    checkOutput("t4.done2", done, 0);

    // Halt wins over memory-busy and a branch
    applyStimulus(0, 0, 3, 8'h55, 1, 1, 1, "halt");
    checkOutput("t5.done", done, 1);
    checkOutput("t5.al", BranchAlways, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "halted");
    checkOutput("t5.fin", Finished, 1);
    checkOutput("t5.cnt", CycleCount, 8);
    applyStimulus(1, 3, 0, 0, 0, 0, 1, "haltBadSel");
    checkOutput("t5.cnt2", CycleCount, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "haltStay");
    checkOutput("t6.busy", Busy, 0);

    // Relaunch from HALT with program 2
    applyStimulus(1, 2, 0, 0, 0, 0, 1, "haltStart");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "relaunch");
    checkOutput("t6.tgt", Target, 8'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "rerun");
    checkOutput("t6.fin", Finished, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, "count");
    checkOutput("t1.pre", CycleCount, 5);

    // Asynchronous reset mid-program
    doReset("midReset");
    checkOutput("t1.done", done, 1);
    checkOutput("t1.busy", Busy, 0);
    checkOutput("t1.cnt", CycleCount, 0);

    applyStimulus(1, 3, 0, 0, 0, 0, 1, "idleBadSel");
    applyStimulus(1, 3, 0, 0, 0, 0, 1, "idleBadSel2");
    checkOutput("t6.idle", Busy, 0);

    // Saturation of the cycle counter during a long stall
    applyStimulus(1, 0, 0, 0, 0, 0, 1, "satStart");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, "satLaunch");
    for (int i = 0; i < CNT_MAX + 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, "sat");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, "satHold");
    checkOutput("sat.cnt", CycleCount, 16'hFFFF);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, "satResume");
    applyStimulus(0, 0, 0, 0, 1, 0, 1, "satHalt");
    checkOutput("sat.halt", CycleCount, 16'hFFFF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 255), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) == 0, 1, "rnd");
      if ($urandom_range(0, 199) == 0) doReset("rndReset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
